// File: rtl/fifo_synchronous_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package fifo_synchronous_pkg;

  localparam int DEFAULT_SIZE_DATA  = 8;
  localparam int DEFAULT_SIZE_DEPTH = 16;

  // Pointer width: one address bit per power of two plus a wrap bit that
  // tells a full buffer apart from an empty one.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_synchronous_if.sv
// Producer/consumer handshake bundle of the synchronous FIFO.
interface fifo_synchronous_if
  import fifo_synchronous_pkg::*;
#(
  parameter int SIZE_DATA = DEFAULT_SIZE_DATA
);

  logic                 i_wr_en;
  logic                 i_rd_en;
  logic [SIZE_DATA-1:0] i_data;
  logic [SIZE_DATA-1:0] o_data;
  logic                 o_full;
  logic                 o_empty;

  // Side that pushes and pops.
  modport master (
    output i_wr_en,
    output i_rd_en,
    output i_data,
    input  o_data,
    input  o_full,
    input  o_empty
  );

  // The FIFO itself.
  modport slave (
    input  i_wr_en,
    input  i_rd_en,
    input  i_data,
    output o_data,
    output o_full,
    output o_empty
  );

endinterface

// File: rtl/fifo_synchronous_mem.sv
// Storage array of the FIFO: one synchronous write port, one registered
// read port whose output register clears on reset and otherwise holds.
module fifo_mem
  import fifo_synchronous_pkg::*;
#(
  parameter int SIZE_DATA  = DEFAULT_SIZE_DATA,
  parameter int SIZE_DEPTH = DEFAULT_SIZE_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          wr_en,
  input  logic [$clog2(SIZE_DEPTH)-1:0] wr_addr,
  input  logic [SIZE_DATA-1:0]          wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(SIZE_DEPTH)-1:0] rd_addr,
  output logic [SIZE_DATA-1:0]          rd_data
);

  logic [SIZE_DATA-1:0] mem_r [SIZE_DEPTH];
  logic [SIZE_DATA-1:0] rd_data_r;

  // Write port; the array is deliberately never cleared.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register: cleared by reset, loads on a read, otherwise holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_data_r <= {SIZE_DATA{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fifo_synchronous.sv
// Single-clock FIFO: pointer and flag logic around the fifo_mem array.
module fifo_synchronous
  import fifo_synchronous_pkg::*;
#(
  parameter int SIZE_DATA  = DEFAULT_SIZE_DATA,
  parameter int SIZE_DEPTH = DEFAULT_SIZE_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_synchronous_if.slave bus
);

  localparam int ADDR_WIDTH = $clog2(SIZE_DEPTH);
  localparam int PTR_WIDTH  = ptr_width(SIZE_DEPTH);

  logic [PTR_WIDTH-1:0] ptr_wr;
  logic [PTR_WIDTH-1:0] ptr_rd;
  logic                 full_s;
  logic                 empty_s;
  logic                 wr_ok_s;
  logic                 rd_ok_s;
  logic [SIZE_DATA-1:0] rd_data_s;

  // Flags come straight from the pointers so they track every edge.
  assign empty_s = (ptr_wr == ptr_rd);
  assign full_s  = (ptr_wr[ADDR_WIDTH] != ptr_rd[ADDR_WIDTH]) &&
                   (ptr_wr[ADDR_WIDTH-1:0] == ptr_rd[ADDR_WIDTH-1:0]);

  // A push into a full buffer is fine when a pop frees a slot on the same edge.
  assign wr_ok_s = bus.i_wr_en & (~full_s | bus.i_rd_en);
  assign rd_ok_s = bus.i_rd_en & ~empty_s;

  // Pointer update; reset wins and discards everything stored.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_wr <= {PTR_WIDTH{1'b0}};
      ptr_rd <= {PTR_WIDTH{1'b0}};
    end else begin
      if (wr_ok_s) begin
        ptr_wr <= ptr_wr + PTR_WIDTH'(1);
      end
      if (rd_ok_s) begin
        ptr_rd <= ptr_rd + PTR_WIDTH'(1);
      end
    end
  end

  fifo_mem #(
    .SIZE_DATA  (SIZE_DATA),
    .SIZE_DEPTH (SIZE_DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .wr_en   (wr_ok_s & ~i_rst),
    .wr_addr (ptr_wr[ADDR_WIDTH-1:0]),
    .wr_data (bus.i_data),
    .rd_en   (rd_ok_s),
    .rd_addr (ptr_rd[ADDR_WIDTH-1:0]),
    .rd_data (rd_data_s)
  );

  assign bus.o_data  = rd_data_s;
  assign bus.o_full  = full_s;
  assign bus.o_empty = empty_s;

endmodule

// File: tb/tb_fifo_synchronous.sv
// Scoreboard bench for fifo_synchronous: stimulus pushes expected read data
// into a queue, a monitor compares o_data after every clock edge.
module tb_fifo_synchronous;

  logic i_clk;
  logic i_rst;

  fifo_synchronous_if #(.SIZE_DATA(8)) bus ();

  fifo_synchronous #(.SIZE_DATA(8), .SIZE_DEPTH(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_q   [$];
  logic [4:0] wcnt = 5'd0;
  logic [4:0] rcnt = 5'd0;
  logic       pop_pending = 1'b0;
  logic       rst_pending = 1'b0;
  logic [7:0] last_popped = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Flags and pointers against the bench's own occupancy model.
  task automatic check_state(input string tag);
    chk({tag, "_full"},   {31'd0, bus.o_full},  {31'd0, (model_q.size() == 16)});
    chk({tag, "_empty"},  {31'd0, bus.o_empty}, {31'd0, (model_q.size() == 0)});
    chk({tag, "_ptr_wr"}, {27'd0, dut.ptr_wr},  {27'd0, wcnt});
    chk({tag, "_ptr_rd"}, {27'd0, dut.ptr_rd},  {27'd0, rcnt});
  endtask

  // One clock of stimulus; the model decides what the FIFO should accept.
  task automatic step(input logic wr, input logic rd, input logic [7:0] d);
    logic rd_ok;
    logic wr_ok;
    rd_ok = rd && (model_q.size() > 0);
    wr_ok = wr && ((model_q.size() < 16) || rd);
    bus.i_wr_en = wr;
    bus.i_rd_en = rd;
    bus.i_data  = d;
    if (rd_ok) begin
      exp_q.push_back(model_q.pop_front());
      rcnt = rcnt + 5'd1;
    end
    if (wr_ok) begin
      model_q.push_back(d);
      wcnt = wcnt + 5'd1;
    end
    pop_pending = rd_ok;
    @(posedge i_clk);
    #2;
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    pop_pending = 1'b0;
    check_state("step");
  endtask

  task automatic do_reset();
    i_rst       = 1'b1;
    rst_pending = 1'b1;
    pop_pending = 1'b0;
    @(posedge i_clk);
    #2;
    i_rst       = 1'b0;
    rst_pending = 1'b0;
    model_q.delete();
    wcnt = 5'd0;
    rcnt = 5'd0;
    check_state("reset");
    chk("reset_o_data", {24'd0, bus.o_data}, 32'h0);
  endtask

  // Monitor: o_data must show the scoreboard head after an accepted pop,
  // zero after reset, and otherwise hold its previous value.
  initial begin
    logic       p;
    logic       r;
    logic [7:0] expv;
    forever begin
      @(posedge i_clk);
      p = pop_pending;
      r = rst_pending;
      #1;
      if (r) begin
        expv = 8'h00;
      end else if (p) begin
        if (exp_q.size() == 0) begin
          expv = last_popped;
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow actual=empty required=entry");
        end else begin
          expv = exp_q.pop_front();
        end
      end else begin
        expv = last_popped;
      end
      last_popped = expv;
      chk("o_data", {24'd0, bus.o_data}, {24'd0, expv});
    end
  end

  initial begin
    bus.i_wr_en = 1'b0;
    bus.i_rd_en = 1'b0;
    bus.i_data  = 8'h00;
    i_rst       = 1'b0;
    #1;

    // Test 1: push then reset
    do_reset();
    step(1'b1, 1'b0, 8'h29);
    do_reset();
    chk("t1_ptr_wr", {27'd0, dut.ptr_wr}, 32'd0);
    chk("t1_empty",  {31'd0, bus.o_empty}, 32'd1);

    // Test 2: 17 pushes, the last one ignored
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 8'h40 + 8'(i * 3));
      if (i == 15) chk("t2_full_16", {31'd0, bus.o_full}, 32'd1);
    end
    chk("t2_ptr_wr", {27'd0, dut.ptr_wr}, 32'd16);
    chk("t2_ptr_rd", {27'd0, dut.ptr_rd}, 32'd0);

    // Test 3: drain 16, then an ignored 17th pop
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b1, 8'h00);
      if (i == 15) begin
        chk("t3_last", {24'd0, bus.o_data}, {24'd0, 8'h40 + 8'd45});
        chk("t3_empty", {31'd0, bus.o_empty}, 32'd1);
      end
    end
    chk("t3_ptr_rd", {27'd0, dut.ptr_rd}, 32'd16);

    // Test 5: wrap-around from pointers at 16
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h50 + 8'(i));
    chk("t5_ptr_wr_wrap", {27'd0, dut.ptr_wr}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      if (i == 0) chk("t5_first", {24'd0, bus.o_data}, 32'h58);
      if (i == 8) chk("t5_new",   {24'd0, bus.o_data}, 32'h80);
    end
    chk("t5_last",   {24'd0, bus.o_data}, 32'h87);
    chk("t5_ptr_rd", {27'd0, dut.ptr_rd}, 32'd8);

    // Test 4: simultaneous push/pop with one word stored
    do_reset();
    step(1'b1, 1'b0, 8'd29);
    for (int v = 30; v <= 33; v++) begin
      step(1'b1, 1'b1, 8'(v));
      chk("t4_o_data", {24'd0, bus.o_data}, 32'(v - 1));
      chk("t4_not_empty", {31'd0, bus.o_empty}, 32'd0);
    end

    // Test 6: push+pop while full
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
    step(1'b1, 1'b1, 8'hAA);
    chk("t6_oldest", {24'd0, bus.o_data}, 32'hC0);
    chk("t6_full",   {31'd0, bus.o_full}, 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("t6_aa_last", {24'd0, bus.o_data}, 32'hAA);
    chk("t6_empty",   {31'd0, bus.o_empty}, 32'd1);

    @(posedge i_clk);
    #3;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
